// File: rtl/fir3_pkg.sv
// fir3_pkg: shared constants for the 3-tap FIR and its inverse.
// Both ends take their default coefficients from here.
package fir3_pkg;

   localparam int X_W   = 8;
   localparam int Y_W   = 18;
   localparam int ACC_W = Y_W + 2;

   localparam int R1_SHIFT = 1;
   localparam int R2       = -4;
   localparam int R3       = 7;

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] M1   = 3'd1;
   localparam logic [2:0] M2   = 3'd2;
   localparam logic [2:0] M3   = 3'd3;
   localparam logic [2:0] DONE = 3'd4;

endpackage

// File: rtl/fir3_inverse_mul.sv
// mul8x8_reg: signed 8x8 multiplier, registered 16-bit product.
// One cycle latency, synchronous active-high reset.
module mul8x8_reg (
   input  logic               clk,
   input  logic               rst,
   input  logic signed [7:0]  a_i,
   input  logic signed [7:0]  b_i,
   output logic signed [15:0] p_o
);

   logic signed [15:0] p_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         p_q <= '0;
      end else begin
         p_q <= a_i * b_i;
      end
   end

   assign p_o = p_q;

endmodule

// File: rtl/fir3_inverse.sv
// fir3_inverse: recovers FIR input samples from the FIR output stream.
// Define FIR3_INV_SATURATE_EN to clamp instead of wrap the quotient.
module fir3_inverse
   import fir3_pkg::*;
#(
   parameter int X_W      = fir3_pkg::X_W,
   parameter int Y_W      = fir3_pkg::Y_W,
   parameter int R1_SHIFT = fir3_pkg::R1_SHIFT,
   parameter int R2       = fir3_pkg::R2,
   parameter int R3       = fir3_pkg::R3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic signed [Y_W-1:0] y_in,
   output logic                  in_ready,
   output logic                  out_valid,
   output logic signed [X_W-1:0] x_out,
   output logic                  inexact,
   output logic                  sat,
   output logic                  overrun
);

   localparam int ACC_W = Y_W + 2;

   localparam logic signed [7:0] R2_C = 8'(R2);
   localparam logic signed [7:0] R3_C = 8'(R3);

   localparam logic signed [ACC_W-1:0] XMAX =
      ACC_W'((1 <<< (X_W - 1)) - 1);
   localparam logic signed [ACC_W-1:0] XMIN =
      ACC_W'(-(1 <<< (X_W - 1)));
   localparam logic [ACC_W-1:0] IMASK =
      ACC_W'((1 << R1_SHIFT) - 1);

   logic [2:0]              state_q, state_d;
   logic signed [Y_W-1:0]   y_q;
   logic signed [X_W-1:0]   x_out_q, x_d1_q, x_d2_q;
   logic signed [ACC_W-1:0] acc_q;
   logic                    out_valid_q, inexact_q;
   logic                    sat_q, overrun_q;

   logic signed [7:0]       mul_a, mul_b;
   logic signed [15:0]      prod;
   logic signed [ACC_W-1:0] q;
   logic                    q_hi, q_lo;
   logic signed [X_W-1:0]   x_fit;

   // M1 forms x[n-1]*R2; every other cycle it forms x[n-2]*R3
   assign mul_a = (state_q == M1) ? x_d1_q : x_d2_q;
   assign mul_b = (state_q == M1) ? R2_C : R3_C;

   mul8x8_reg u_mul (
      .clk (clk),
      .rst (rst),
      .a_i (mul_a),
      .b_i (mul_b),
      .p_o (prod)
   );

   assign q    = acc_q >>> R1_SHIFT;
   assign q_hi = (q > XMAX);
   assign q_lo = (q < XMIN);

`ifdef FIR3_INV_SATURATE_EN
   assign x_fit = q_hi ? XMAX[X_W-1:0] :
                  q_lo ? XMIN[X_W-1:0] : q[X_W-1:0];
`else
   assign x_fit = q[X_W-1:0];
`endif

   assign in_ready = (state_q == IDLE);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (in_valid) state_d = M1;
         M1:      state_d = M2;
         M2:      state_d = M3;
         M3:      state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         y_q         <= '0;
         x_out_q     <= '0;
         x_d1_q      <= '0;
         x_d2_q      <= '0;
         acc_q       <= '0;
         out_valid_q <= 1'b0;
         inexact_q   <= 1'b0;
         sat_q       <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= 1'b0;
         if (in_valid && !in_ready) overrun_q <= 1'b1;
         unique case (state_q)
            IDLE: if (in_valid) y_q <= y_in;
            M2:   acc_q <= ACC_W'(y_q) - ACC_W'(prod);
            M3:   acc_q <= acc_q - ACC_W'(prod);
            DONE: begin
               x_out_q     <= x_fit;
               out_valid_q <= 1'b1;
               inexact_q   <= |(acc_q & IMASK);
               sat_q       <= q_hi | q_lo;
               x_d2_q      <= x_d1_q;
               x_d1_q      <= x_fit;
            end
            default: ;
         endcase
      end
   end

   assign out_valid = out_valid_q;
   assign x_out     = x_out_q;
   assign inexact   = inexact_q;
   assign sat       = sat_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_fir3_inverse.sv
// tb_fir3_inverse: directed vectors plus a per-cycle behavioural model.
// Build with FIR3_INV_SATURATE_EN to check the clamping variant.
module tb_fir3_inverse;

   localparam int R1S = 1;
   localparam int CR2 = -4;
   localparam int CR3 = 7;

   logic               clk = 1'b0;
   logic               rst;
   logic               in_valid;
   logic signed [17:0] y_in;
   logic               in_ready;
   logic               out_valid;
   logic signed [7:0]  x_out;
   logic               inexact;
   logic               sat;
   logic               overrun;

   int errs   = 0;
   int checks = 0;

   fir3_inverse dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .y_in      (y_in),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .x_out     (x_out),
      .inexact   (inexact),
      .sat       (sat),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d at %0t",
                  nm, act, exp, $time);
      end
   endtask

   // model state: cycles left until the result, history, outputs
   int m_left = 0;
   int m_y = 0;
   int m_h1 = 0;
   int m_h2 = 0;
   int m_x = 0;
   int m_ov = 0;
   int m_inex = 0;
   int m_sat = 0;
   int m_over = 0;

   initial begin
      int num, d, qq, w;
      forever begin
         @(posedge clk);
         if (rst) begin
            m_left = 0; m_y = 0; m_h1 = 0; m_h2 = 0;
            m_x = 0; m_ov = 0; m_inex = 0; m_sat = 0; m_over = 0;
         end else begin
            m_ov = 0;
            if (m_left > 0) begin
               if (in_valid) m_over = 1;
               m_left--;
               if (m_left == 0) begin
                  num = m_y - CR2 * m_h1 - CR3 * m_h2;
                  d   = 1 << R1S;
                  qq  = num / d;
                  if ((num % d) != 0 && num < 0) qq--;
                  m_inex = ((num % d) != 0) ? 1 : 0;
                  m_sat  = (qq > 127 || qq < -128) ? 1 : 0;
`ifdef FIR3_INV_SATURATE_EN
                  w = (qq > 127) ? 127 : (qq < -128) ? -128 : qq;
`else
                  w = qq & 255;
                  if (w > 127) w -= 256;
`endif
                  m_x  = w;
                  m_h2 = m_h1;
                  m_h1 = w;
                  m_ov = 1;
               end
            end else if (in_valid) begin
               m_y    = y_in;
               m_left = 4;
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         chk("out_valid", out_valid, m_ov);
         chk("in_ready", in_ready, (m_left == 0) ? 1 : 0);
         chk("overrun", overrun, m_over);
         chk("x_out", x_out, m_x);
         if (m_ov != 0) begin
            chk("inexact", inexact, m_inex);
            chk("sat", sat, m_sat);
         end
      end
   end

   task automatic send(input int y, output int lat, output int xv,
                       output int inx, output int st);
      int n;
      n = 0;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("send_ready", in_ready, 1);
      in_valid = 1'b1;
      y_in = 18'(y);
      lat = -1; xv = 0; inx = 0; st = 0;
      for (int j = 0; j < 12; j++) begin
         @(negedge clk);
         if (j == 0) in_valid = 1'b0;
         if (out_valid) begin
            lat = j; xv = x_out; inx = inexact; st = sat;
            break;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout at %0t", $time);
      errs++;
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $fatal(1, "timeout");
   end

   initial begin
      int ys[5];
      int xs[5];
      int lat, xv, inx, st, pulses;
      ys = '{-6, 30, -49, 31, 64};
      xs = '{-3, 9, 4, -8, 2};
      rst = 1'b1;
      in_valid = 1'b0;
      y_in = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_x_out", x_out, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_overrun", overrun, 0);

      for (int i = 0; i < 5; i++) begin
         send(ys[i], lat, xv, inx, st);
         chk("loop_latency", lat, 4);
         chk("loop_x", xv, xs[i]);
         chk("loop_inexact", inx, 0);
         chk("loop_sat", st, 0);
         repeat (5) @(negedge clk);
      end

      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         chk("idle_x_out", x_out, 2);
         chk("idle_out_valid", out_valid, 0);
         chk("idle_in_ready", in_ready, 1);
      end

      in_valid = 1'b1;
      y_in = -18'sd6;
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (out_valid) pulses++;
      end
      in_valid = 1'b0;
      chk("b2b_pulses", pulses, 4);
      chk("b2b_overrun", overrun, 1);
      repeat (10) @(negedge clk);

      do_reset();
      send(7, lat, xv, inx, st);
      chk("inex1_x", xv, 3);
      chk("inex1_flag", inx, 1);
      send(-7, lat, xv, inx, st);
      chk("inex2_x", xv, 2);
      chk("inex2_flag", inx, 1);

      do_reset();
      send(400, lat, xv, inx, st);
      chk("sat_flag", st, 1);
`ifdef FIR3_INV_SATURATE_EN
      chk("sat_x", xv, 127);
`else
      chk("sat_x", xv, -56);
`endif

      in_valid = 1'b1;
      y_in = 18'sd30;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_x_out", x_out, 0);
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_inexact", inexact, 0);
      chk("midrst_sat", sat, 0);
      chk("midrst_overrun", overrun, 0);
      chk("midrst_in_ready", in_ready, 1);
      repeat (6) @(negedge clk);
      send(-6, lat, xv, inx, st);
      chk("midrst_after_lat", lat, 4);
      chk("midrst_after_x", xv, -3);
      repeat (5) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
